// File: rtl/rotate_cmd_issue.sv
// rotate_cmd_issue: FIFO-buffered rotate command stage with a registered
// valid/ready result. The FIFO head is rotated combinationally and captured
// into the result register when that register is free or being drained.

module barrel_shifter_multi_rev (
  input  logic [7:0] data_in,
  input  logic [2:0] amt,
  input  logic       dir_lr,
  output logic [7:0] data_out
);

  logic [7:0] s1;
  logic [7:0] s2;

  // Three log stages (1, 2, 4 positions); dir_lr picks left or right per stage
  always_comb begin
    s1 = data_in;
    s2 = data_in;
    data_out = data_in;
    if (amt[0]) s1 = dir_lr ? {data_in[6:0], data_in[7]} : {data_in[0], data_in[7:1]};
    else        s1 = data_in;
    if (amt[1]) s2 = dir_lr ? {s1[5:0], s1[7:6]} : {s1[1:0], s1[7:2]};
    else        s2 = s1;
    if (amt[2]) data_out = {s2[3:0], s2[7:4]};
    else        data_out = s2;
  end

endmodule

module rotate_cmd_issue #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [7:0]                    cmd_data,
  input  logic [2:0]                    cmd_amt,
  input  logic                          cmd_dir,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [7:0]                    res_data,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          issue;
  logic [11:0]   head;
  logic [7:0]    rot_out;

  assign head       = mem[rd_ptr];
  assign cmd_ready  = (count != FULL_CNT);
  assign fill_level = count;

  // Handshake decode; both terms depend only on registered state and inputs
  always_comb begin
    push  = cmd_valid && cmd_ready;
    issue = (count != '0) && (!res_valid || res_ready);
  end

  barrel_shifter_multi_rev u_rot (
    .data_in  (head[7:0]),
    .amt      (head[10:8]),
    .dir_lr   (head[11]),
    .data_out (rot_out)
  );

  // Command storage: entry = {dir, amt, data}; not reset, validity tracked by count
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {cmd_dir, cmd_amt, cmd_data};
  end

  // Pointers, occupancy and result register; flush overrides push/issue/drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      if (push && !issue)      count <= count + 1'b1;
      else if (!push && issue) count <= count - 1'b1;
      if (issue) begin
        res_valid <= 1'b1;
        res_data  <= rot_out;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rotate_cmd_issue.sv
// Testbench for rotate_cmd_issue: directed vectors plus randomized traffic,
// checked by a queue-based reference model in a separate monitor process.

module tb_rotate_cmd_issue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = '0;
  logic [2:0] cmd_amt = '0;
  logic       cmd_dir = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [2:0] fill_level;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: expected results in order, result-register
  // occupancy and number of commands still waiting in the FIFO.
  logic [7:0] exp_q[$];
  bit         m_rv = 0;
  int         m_fifo = 0;

  rotate_cmd_issue #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_amt    (cmd_amt),
    .cmd_dir    (cmd_dir),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rot_ref(input logic [7:0] d, input int a, input bit left);
    logic [15:0] t;
    t = {d, d};
    if (left) t = t >> ((8 - a) % 8);
    else      t = t >> a;
    return t[7:0];
  endfunction

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Monitor: inputs are stable at the falling edge, so compare outputs here
  // and advance the model by what the coming rising edge will do.
  always @(negedge clk) begin
    bit acc;
    bit iss;
    if (!rst_n) begin
      exp_q.delete();
      m_rv = 0;
      m_fifo = 0;
    end else begin
      chk("res_valid", {31'b0, res_valid}, {31'b0, m_rv});
      chk("fill_level", {29'b0, fill_level}, m_fifo);
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, (m_fifo != DEPTH)});
      if (m_rv && exp_q.size() > 0) chk("res_data", {24'b0, res_data}, {24'b0, exp_q[0]});
      acc = cmd_valid && (m_fifo != DEPTH);
      if (flush) begin
        exp_q.delete();
        m_rv = 0;
        m_fifo = 0;
      end else begin
        iss = (m_fifo > 0) && (!m_rv || res_ready);
        if (m_rv && res_ready) begin
          void'(exp_q.pop_front());
          m_rv = 0;
        end
        if (iss) begin
          m_rv = 1;
          m_fifo--;
        end
        if (acc) begin
          exp_q.push_back(rot_ref(cmd_data, int'(cmd_amt), cmd_dir));
          m_fifo++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic dr);
    bit ok;
    bit rdy;
    ok = 0;
    cmd_valid = 1'b1;
    cmd_data = d;
    cmd_amt = a;
    cmd_dir = dr;
    for (int i = 0; i < 100 && !ok; i++) begin
      rdy = cmd_ready;
      tick();
      if (rdy) ok = 1;
    end
    cmd_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic single(input logic [7:0] d, input logic [2:0] a, input logic dr,
                        input logic [7:0] expv);
    send(d, a, dr);
    chk("latency_early", {31'b0, res_valid}, 0);
    tick();
    chk("latency_valid", {31'b0, res_valid}, 1);
    chk("single_data", {24'b0, res_data}, {24'b0, expv});
    tick();
  endtask

  initial begin
    int vcnt;
    #12;
    chk("rst_res_valid", {31'b0, res_valid}, 0);
    chk("rst_res_data", {24'b0, res_data}, 0);
    chk("rst_fill", {29'b0, fill_level}, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    tick();
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);

    res_ready = 1'b1;
    single(8'h81, 3'd1, 1'b1, 8'h03);
    single(8'h01, 3'd1, 1'b0, 8'h80);
    single(8'hA5, 3'd0, 1'b1, 8'hA5);
    single(8'hF0, 3'd4, 1'b0, 8'h0F);
    single(8'h96, 3'd3, 1'b1, 8'hB4);

    // Backpressure: five accepted, sixth held until the consumer resumes
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h11 << i, 3'(i + 1), i[0]);
    chk("bp_fill", {29'b0, fill_level}, 4);
    chk("bp_ready", {31'b0, cmd_ready}, 0);
    chk("bp_valid", {31'b0, res_valid}, 1);
    cmd_valid = 1'b1;
    cmd_data = 8'h3C;
    cmd_amt = 3'd5;
    cmd_dir = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_held_fill", {29'b0, fill_level}, 4);
    res_ready = 1'b1;
    send(8'h3C, 3'd5, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    chk("bp_drain_fill", {29'b0, fill_level}, 0);
    chk("bp_drain_valid", {31'b0, res_valid}, 0);

    // Streaming: 16 back-to-back commands give 16 consecutive valid cycles
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'($urandom), 3'($urandom), 1'($urandom));
      vcnt += int'(res_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vcnt += int'(res_valid);
    end
    chk("stream_valid_cycles", vcnt, 16);

    // Flush with a held result and three queued; concurrent command dropped
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hC3 + 8'(i), 3'(i), 1'b0);
    chk("pre_flush_fill", {29'b0, fill_level}, 3);
    chk("pre_flush_valid", {31'b0, res_valid}, 1);
    flush = 1'b1;
    cmd_valid = 1'b1;
    tick();
    flush = 1'b0;
    cmd_valid = 1'b0;
    chk("flush_fill", {29'b0, fill_level}, 0);
    chk("flush_valid", {31'b0, res_valid}, 0);
    chk("flush_ready", {31'b0, cmd_ready}, 1);
    res_ready = 1'b1;
    tick();
    chk("flush_no_stale", {31'b0, res_valid}, 0);

    // Random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom % 4) != 0;
      cmd_data = 8'($urandom);
      cmd_amt = 3'($urandom);
      cmd_dir = 1'($urandom);
      res_ready = ($urandom % 3) != 0;
      flush = ($urandom % 40) == 0;
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, res_valid}, 0);
        chk("async_rst_data", {24'b0, res_data}, 0);
        chk("async_rst_fill", {29'b0, fill_level}, 0);
        cmd_valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
      tick();
    end
    cmd_valid = 1'b0;
    flush = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("final_fill", {29'b0, fill_level}, 0);
    chk("final_valid", {31'b0, res_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
